jtj_accumulator: RTL and testbench

// - Upstream stage of the Cholesky/inverse engine. Builds the 6x6 symmetric normal matrix A = sum(r^T r).
// - Rows r arrive one at a time as a stream of Jacobian rows.
// - Optionally adds Levenberg-Marquardt damping (lambda) to the diagonal.
// - Presents the full mirrored matrix to the inverse stage with a valid/ready handshake.

---
 rtl/jtj_accumulator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_jtj_accumulator.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtj_accumulator.sv
// -----------------------------------------------------------------------------
// jtj_accumulator
//
// Purpose:
//   Upstream stage of the Cholesky/inverse engine. Accumulates the symmetric
//   normal matrix A = sum(r^T r) over a frame of NUM_ROWS Jacobian rows. Each
//   row is processed over N MAC cycles. Cycle k updates the k-th row of the
//   upper triangle using N parallel multipliers. The finished matrix is
//   presented mirrored (lower = upper) and held until the inverse stage takes
//   it with a valid/ready handshake.
//
// Optional feature:
//   `define LM_DAMPING_EN  adds a one-cycle DAMP state after the last row.
//                          That state adds lambda (saturating) to every
//                          diagonal element. When the macro is undefined,
//                          lambda is ignored and the last MAC goes straight
//                          to OUT.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   row_valid  in   row_data valid
//   row_ready  out  block can accept a row (state ACCEPT)
//   row_data   in   [N-1:0][W-1:0] Jacobian row, signed Q(W-FRAC).FRAC
//   lambda     in   [W-1:0] damping value (used only with LM_DAMPING_EN)
//   abort      in   synchronous frame flush, highest priority
//   mat_valid  out  mat_out holds a complete frame (state OUT)
//   mat_ready  in   inverse stage consumes the frame
//   mat_out    out  [N-1:0][N-1:0][W-1:0] full symmetric matrix
//   sat_flag   out  sticky saturation flag for the current frame
//   busy       out  state != ACCEPT
// -----------------------------------------------------------------------------
module jtj_accumulator #(
    parameter int N        = 6,
    parameter int W        = 27,
    parameter int FRAC     = 16,
    parameter int NUM_ROWS = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic [N-1:0][W-1:0]             row_data,
    input  logic [W-1:0]                    lambda,
    input  logic                            abort,
    output logic                            mat_valid,
    input  logic                            mat_ready,
    output logic [N-1:0][N-1:0][W-1:0]      mat_out,
    output logic                            sat_flag,
    output logic                            busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(NUM_ROWS + 1);
    localparam int NT = N * (N + 1) / 2;

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
`ifdef LM_DAMPING_EN
    localparam logic [1:0] S_DAMP   = 2'd2;
`endif
    localparam logic [1:0] S_OUT    = 2'd3;

    // Linear position of upper-triangle element (i,j), j >= i, row-major.
    function automatic int tri_idx(input int i, input int j);
        return i * N - (i * (i - 1)) / 2 + (j - i);
    endfunction

    logic [1:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         row_cnt_q, row_cnt_d;
    logic [N-1:0][W-1:0]   row_q, row_d;
    logic                  sat_q, sat_d;
    logic                  clr;
    logic [NT-1:0]         elem_ovf;

`ifndef LM_DAMPING_EN
    logic lambda_unused;
    assign lambda_unused = ^lambda;
`endif

    // Frame flush: abort, or the inverse stage taking the finished matrix.
    assign clr = abort || (state_q == S_OUT && mat_ready);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_cnt_d = row_cnt_q;
        row_d     = row_q;
        case (state_q)
            S_ACCEPT: begin
                if (row_valid) begin
                    row_d   = row_data;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == KW'(N - 1)) begin
                    k_d       = '0;
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == CW'(NUM_ROWS - 1)) begin
`ifdef LM_DAMPING_EN
                        state_d = S_DAMP;
`else
                        state_d = S_OUT;
`endif
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`ifdef LM_DAMPING_EN
            S_DAMP: begin
                state_d = S_OUT;
            end
`endif
            S_OUT: begin
                if (mat_ready) begin
                    row_cnt_d = '0;
                    state_d   = S_ACCEPT;
                end
            end
            default: begin
                state_d = S_ACCEPT;
            end
        endcase
        if (abort) begin
            state_d   = S_ACCEPT;
            k_d       = '0;
            row_cnt_d = '0;
        end
    end

    always_comb begin
        sat_d = sat_q | (|elem_ovf);
        if (clr) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ACCEPT;
            k_q       <= '0;
            row_cnt_q <= '0;
            row_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_cnt_q <= row_cnt_d;
            row_q     <= row_d;
            sat_q     <= sat_d;
        end
    end

    assign row_ready = (state_q == S_ACCEPT);
    assign mat_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_ACCEPT);
    assign sat_flag  = sat_q;

    // -------------------------------------------------------------------------
    // Multipliers: row_q[k] times every row element, one product per column.
    // -------------------------------------------------------------------------
    logic [W-1:0]        mul_a;
    logic [N-1:0][W-1:0] psat;
    logic [N-1:0]        povf;

    always_comb begin
        mul_a = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                mul_a = row_q[i];
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mul
            logic signed [2*W-1:0] a_ext, b_ext, prod, prod_sh;
            assign a_ext   = {{W{mul_a[W-1]}}, mul_a};
            assign b_ext   = {{W{row_q[gi][W-1]}}, row_q[gi]};
            // Both operands are sign-extended to 2W, so the low 2W bits of the
            // product are the exact signed result.
            assign prod    = a_ext * b_ext;
            // Arithmetic shift: truncation toward minus infinity.
            assign prod_sh = prod >>> FRAC;
            // Fits in W bits only if every bit above W-2 repeats the sign.
            assign povf[gi] = (prod_sh[2*W-1:W-1] != {(W+1){prod_sh[2*W-1]}});
            assign psat[gi] = povf[gi] ? (prod_sh[2*W-1] ? SMIN : SMAX)
                                       : prod_sh[W-1:0];
        end

        // ---------------------------------------------------------------------
        // Upper-triangle accumulators; each also drives its mirrored output.
        // ---------------------------------------------------------------------
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = gi; gj < N; gj++) begin : g_col
                localparam int IDX = tri_idx(gi, gj);

                logic [W-1:0] acc_q, acc_d, addend;
                logic [W:0]   sum;
                logic         add_en, in_ovf, sum_ovf;

                always_comb begin
                    addend = psat[gj];
                    add_en = 1'b0;
                    in_ovf = 1'b0;
                    if (state_q == S_MAC && k_q == KW'(gi)) begin
                        add_en = 1'b1;
                        in_ovf = povf[gj];
                    end
`ifdef LM_DAMPING_EN
                    if (gi == gj && state_q == S_DAMP) begin
                        addend = lambda;
                        add_en = 1'b1;
                    end
`endif
                end

                // W+1-bit sum; overflow when the two top bits disagree.
                assign sum     = {acc_q[W-1], acc_q} + {addend[W-1], addend};
                assign sum_ovf = (sum[W] != sum[W-1]);

                always_comb begin
                    acc_d = acc_q;
                    if (clr) begin
                        acc_d = '0;
                    end else if (add_en) begin
                        acc_d = sum_ovf ? (sum[W] ? SMIN : SMAX) : sum[W-1:0];
                    end
                end

                assign elem_ovf[IDX] = add_en && (in_ovf || sum_ovf);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        acc_q <= '0;
                    end else begin
                        acc_q <= acc_d;
                    end
                end

                assign mat_out[gi][gj] = acc_q;
                if (gj != gi) begin : g_mirror
                    assign mat_out[gj][gi] = acc_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_jtj_accumulator.sv
// -----------------------------------------------------------------------------
// tb_jtj_accumulator
//
// Two instances share the clock and reset: dut6 (NUM_ROWS=6) and dut1
// (NUM_ROWS=1). The stimulus process pushes the hand-computed expected matrix
// of each frame into that instance's queue before sending the rows. A monitor
// pops and compares whenever an instance presents mat_valid && mat_ready.
// Directed checks (reset, latency, backpressure, abort, async reset) run
// inline in the stimulus process.
// -----------------------------------------------------------------------------
module tb_jtj_accumulator;

    localparam int N    = 6;
    localparam int W    = 27;
    localparam int FRAC = 16;
    localparam int LAMBDA = 32768;
    localparam longint MAXV = 67108863;
    localparam longint MINV = -67108864;
`ifdef LM_DAMPING_EN
    localparam int DAMP_LAT = 1;
`else
    localparam int DAMP_LAT = 0;
`endif

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
    typedef logic [N-1:0][W-1:0]        row_t;
    typedef struct {
        mat_t m;
        logic sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] lambda;

    logic row_valid6, row_ready6, abort6, mat_valid6, mat_ready6, sat_flag6, busy6;
    row_t row_data6;
    mat_t mat_out6;
    logic row_valid1, row_ready1, abort1, mat_valid1, mat_ready1, sat_flag1, busy1;
    row_t row_data1;
    mat_t mat_out1;

    int checks = 0;
    int errors = 0;
    int fr6 = 0;
    int fr1 = 0;

    exp_t q6[$];
    exp_t q1[$];
    mat_t em;
    logic es;

    always #5 clk = ~clk;

    jtj_accumulator #(.N(N), .W(W), .FRAC(FRAC), .NUM_ROWS(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .row_valid(row_valid6), .row_ready(row_ready6), .row_data(row_data6),
        .lambda(lambda), .abort(abort6),
        .mat_valid(mat_valid6), .mat_ready(mat_ready6), .mat_out(mat_out6),
        .sat_flag(sat_flag6), .busy(busy6)
    );

    jtj_accumulator #(.N(N), .W(W), .FRAC(FRAC), .NUM_ROWS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .row_valid(row_valid1), .row_ready(row_ready1), .row_data(row_data1),
        .lambda(lambda), .abort(abort1),
        .mat_valid(mat_valid1), .mat_ready(mat_ready1), .mat_out(mat_out1),
        .sat_flag(sat_flag1), .busy(busy1)
    );

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end else begin
            $display("check %s ok (%0h)", name, got);
        end
    endtask

    task automatic clr_exp();
        em = '0;
        es = 1'b0;
    endtask

    task automatic set_up(input int i, input int j, input int v);
        em[i][j] = W'(v);
        em[j][i] = W'(v);
    endtask

    // Queue the expected frame; with damping, lambda goes onto the diagonal.
    task automatic push_exp(input int id);
        exp_t e;
`ifdef LM_DAMPING_EN
        longint s;
        for (int d = 0; d < N; d++) begin
            s = longint'($signed(em[d][d])) + longint'(LAMBDA);
            if (s > MAXV) begin s = MAXV; es = 1'b1; end
            if (s < MINV) begin s = MINV; es = 1'b1; end
            em[d][d] = W'(s);
        end
`endif
        e.m   = em;
        e.sat = es;
        if (id == 6) q6.push_back(e);
        else         q1.push_back(e);
    endtask

    function automatic row_t ident_row(input int k);
        row_t r;
        r    = '0;
        r[k] = W'(65536);
        return r;
    endfunction

    task automatic send_row(input int id, input row_t r);
        int  n;
        logic rdy;
        n = 0;
        if (id == 6) begin row_data6 = r; row_valid6 = 1'b1; end
        else         begin row_data1 = r; row_valid1 = 1'b1; end
        do begin
            @(negedge clk);
            n++;
            rdy = (id == 6) ? row_ready6 : row_ready1;
        end while (!rdy && n < 100);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL row_accept_timeout dut%0d: row_ready stayed 0, required 1", id);
        end
        @(posedge clk);
        #1;
        if (id == 6) row_valid6 = 1'b0;
        else         row_valid1 = 1'b0;
    endtask

    task automatic wait_drain(input int id);
        int n;
        int sz;
        n  = 0;
        sz = (id == 6) ? q6.size() : q1.size();
        while (sz != 0 && n < 300) begin
            @(negedge clk);
            n++;
            sz = (id == 6) ? q6.size() : q1.size();
        end
        if (sz != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout dut%0d: %0d frames pending, required 0", id, sz);
            if (id == 6) q6.delete();
            else         q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic identity_frame6();
        clr_exp();
        for (int d = 0; d < N; d++) set_up(d, d, 65536);
        push_exp(6);
        for (int k = 0; k < N; k++) send_row(6, ident_row(k));
        wait_drain(6);
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic check_frame(input int id, input mat_t act, input logic act_sat);
        exp_t e;
        int   bi, bj, fr;
        bit   bad;
        if ((id == 6 && q6.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d: frame presented, required none pending", id);
            return;
        end
        if (id == 6) begin e = q6.pop_front(); fr6++; fr = fr6; end
        else         begin e = q1.pop_front(); fr1++; fr = fr1; end
        bad = 1'b0;
        bi  = 0;
        bj  = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!bad && act[i][j] !== e.m[i][j]) begin
                    bad = 1'b1;
                    bi  = i;
                    bj  = j;
                end
            end
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL frame_matrix dut%0d frame %0d: mat_out[%0d][%0d] got %0d, required %0d",
                     id, fr, bi, bj, $signed(act[bi][bj]), $signed(e.m[bi][bj]));
        end else begin
            $display("dut%0d frame %0d: matrix ok, diag0=%0d", id, fr, $signed(act[0][0]));
        end
        checks++;
        if (act_sat !== e.sat) begin
            errors++;
            $display("FAIL frame_sat dut%0d frame %0d: sat_flag got %0b, required %0b",
                     id, fr, act_sat, e.sat);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mat_valid6 && mat_ready6) check_frame(6, mat_out6, sat_flag6);
        if (rst_n === 1'b1 && mat_valid1 && mat_ready1) check_frame(1, mat_out1, sat_flag1);
    end

    // ---------------------------------------------------------------- stimulus
    row_t r;
    mat_t snap;
    bit   stable, held;
    int   lat;

    initial begin
        rst_n      = 1'b0;
        lambda     = W'(LAMBDA);
        row_valid6 = 1'b0; row_data6 = '0; abort6 = 1'b0; mat_ready6 = 1'b1;
        row_valid1 = 1'b0; row_data1 = '0; abort1 = 1'b0; mat_ready1 = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_row_ready6", row_ready6, 1);
        chk("reset_mat_valid6", mat_valid6, 0);
        chk("reset_sat6",       sat_flag6,  0);
        chk("reset_busy6",      busy6,      0);
        chk("reset_mat_zero6",  mat_out6 == '0, 1);
        chk("reset_row_ready1", row_ready1, 1);
        chk("reset_mat_valid1", mat_valid1, 0);
        chk("reset_busy1",      busy1,      0);
        chk("reset_mat_zero1",  mat_out1 == '0, 1);
        @(posedge clk);
        #1;

        // Identity frame on the 6-row instance.
        identity_frame6();

        // Uniform 2.0 row on the 1-row instance, with latency and backpressure.
        clr_exp();
        for (int i = 0; i < N; i++)
            for (int j = i; j < N; j++) set_up(i, j, 262144);
        push_exp(1);
        r = '0;
        for (int i = 0; i < N; i++) r[i] = W'(131072);
        send_row(1, r);
        @(negedge clk);
        chk("busy_after_accept", {row_ready1, busy1}, 2'b01);
        // lat = number of rising edges after the accepting edge.
        lat = 0;
        while (!mat_valid1 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("valid_latency", lat, N + DAMP_LAT);
        snap       = mat_out1;
        stable     = 1'b1;
        held       = 1'b1;
        row_valid1 = 1'b1;
        row_data1  = '0;
        repeat (20) begin
            @(negedge clk);
            if (mat_out1 !== snap) stable = 1'b0;
            if (row_ready1 !== 1'b0 || mat_valid1 !== 1'b1) held = 1'b0;
        end
        row_valid1 = 1'b0;
        chk("bp_mat_stable", stable, 1);
        chk("bp_valid_held_ready_low", held, 1);
        @(posedge clk);
        #1 mat_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_mat_valid", mat_valid1, 0);
        chk("release_row_ready", row_ready1, 1);
        chk("release_queue_empty", q1.size(), 0);
        @(posedge clk);
        #1;

        // Positive and negative saturation.
        clr_exp();
        set_up(0, 0, 67108863);
        set_up(1, 1, 67108863);
        set_up(0, 1, -67108864);
        es = 1'b1;
        push_exp(1);
        r    = '0;
        r[0] = W'(67108863);
        r[1] = W'(-67108864);
        send_row(1, r);
        wait_drain(1);

        // Mixed signs and truncation toward minus infinity.
        clr_exp();
        set_up(0, 0, 65536);  set_up(0, 1, -98304); set_up(0, 2, -1);
        set_up(0, 3, 1);      set_up(0, 5, -32768);
        set_up(1, 1, 147456); set_up(1, 2, 1);      set_up(1, 3, -2);
        set_up(1, 5, 49152);  set_up(2, 3, -1);     set_up(3, 5, -1);
        set_up(5, 5, 16384);
        push_exp(1);
        r    = '0;
        r[0] = W'(-65536);
        r[1] = W'(98304);
        r[2] = W'(1);
        r[3] = W'(-1);
        r[5] = W'(32768);
        send_row(1, r);
        wait_drain(1);

        // Abort on the 3rd MAC cycle of row 4, then a clean identity frame.
        for (int k = 0; k < 3; k++) send_row(6, ident_row(k));
        send_row(6, ident_row(3));
        @(posedge clk);
        @(posedge clk);
        #1 abort6 = 1'b1;
        @(posedge clk);
        #1 abort6 = 1'b0;
        @(negedge clk);
        chk("abort_state_accept", {busy6, row_ready6, mat_valid6}, 3'b010);
        chk("abort_acc_zero", mat_out6 == '0, 1);
        chk("abort_sat_clear", sat_flag6, 0);
        @(posedge clk);
        #1;
        identity_frame6();

        // Asynchronous reset in the middle of a row: immediate clear.
        send_row(6, ident_row(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {busy6, row_ready6}, 2'b01);
        chk("async_rst_acc_zero", mat_out6 == '0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        identity_frame6();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
